// File: rtl/bfu_pipe.sv
// Radix-2 DIT butterfly (out_a = a + b*w, out_b = a - b*w), 4-stage valid/ready pipeline with full stall.
// Define BFU_SAT_EN for saturating outputs and a live ovf_flag; otherwise outputs wrap and ovf_flag is 0.
module bfu_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_a,
  input  logic [2*DATA_W-1:0]   in_b,
  input  logic [2*TW_W-1:0]     twiddle,
  input  logic                  scale_in,
  input  logic                  inv_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_a,
  output logic [2*DATA_W-1:0]   out_b,
  output logic                  ovf_flag
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = DATA_W + 2;
  localparam logic signed [PW:0]   RND = {{(PW+2-TW_W){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
  localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

  function automatic logic signed [TW_W-1:0] neg_sat(input logic signed [TW_W-1:0] x);
    if (x == {1'b1, {(TW_W-1){1'b0}}}) return {1'b0, {(TW_W-1){1'b1}}};
    return -x;
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [DATA_W-1:0] x,
                                               input logic signed [TW_W-1:0] y);
    logic signed [PW-1:0] xe, ye;
    xe = {{TW_W{x[DATA_W-1]}}, x};
    ye = {{DATA_W{y[TW_W-1]}}, y};
    return xe * ye;
  endfunction

  // Round half-up back to data scale, keeping DATA_W+1 bits.
  function automatic logic signed [DATA_W:0] round_prod(input logic signed [PW:0] p);
    logic signed [PW:0] r;
    r = (p + RND) >>> (TW_W - 1);
    return r[DATA_W:0];
  endfunction

  function automatic logic signed [SW-1:0] s4_sum(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W:0] p,
                                                  input logic neg);
    logic signed [SW-1:0] ae, pe;
    ae = {{2{a[DATA_W-1]}}, a};
    pe = {p[DATA_W], p};
    return neg ? (ae - pe) : (ae + pe);
  endfunction

  function automatic logic signed [SW-1:0] half_round(input logic signed [SW-1:0] s,
                                                      input logic en);
    logic signed [SW-1:0] t;
    t = s + ONE;
    return en ? (t >>> 1) : s;
  endfunction

`ifdef BFU_SAT_EN
  function automatic logic oor(input logic signed [SW-1:0] s);
    return !((&s[SW-1:DATA_W-1]) || !(|s[SW-1:DATA_W-1]));
  endfunction
`endif

  function automatic logic [DATA_W-1:0] reduce(input logic signed [SW-1:0] s);
`ifdef BFU_SAT_EN
    if (oor(s)) return s[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return s[DATA_W-1:0];
  endfunction

  logic advance;
  logic vld_p1, vld_p2, vld_p3;
  logic signed [DATA_W-1:0] ar_p1, ai_p1, br_p1, bi_p1;
  logic signed [TW_W-1:0]   wr_p1, wi_p1;
  logic                     scale_p1;
  logic signed [DATA_W-1:0] ar_p2, ai_p2;
  logic signed [PW-1:0]     prr_p2, pii_p2, pri_p2, pir_p2;
  logic                     scale_p2;
  logic signed [DATA_W-1:0] ar_p3, ai_p3;
  logic signed [DATA_W:0]   pr_p3, pi_p3;
  logic                     scale_p3;
  logic signed [SW-1:0]     sar, sai, sbr, sbi;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk) begin
    if (clear) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      // S1: capture operands, conjugate twiddle in inverse mode
      ar_p1    <= in_a[DATA_W-1:0];
      ai_p1    <= in_a[2*DATA_W-1:DATA_W];
      br_p1    <= in_b[DATA_W-1:0];
      bi_p1    <= in_b[2*DATA_W-1:DATA_W];
      wr_p1    <= twiddle[TW_W-1:0];
      wi_p1    <= inv_in ? neg_sat(twiddle[2*TW_W-1:TW_W]) : twiddle[2*TW_W-1:TW_W];
      scale_p1 <= scale_in;
      // S2: partial products
      ar_p2    <= ar_p1;
      ai_p2    <= ai_p1;
      scale_p2 <= scale_p1;
      prr_p2   <= mul(br_p1, wr_p1);
      pii_p2   <= mul(bi_p1, wi_p1);
      pri_p2   <= mul(br_p1, wi_p1);
      pir_p2   <= mul(bi_p1, wr_p1);
      // S3: complex product, rounded to data scale
      ar_p3    <= ar_p2;
      ai_p3    <= ai_p2;
      scale_p3 <= scale_p2;
      pr_p3    <= round_prod({prr_p2[PW-1], prr_p2} - {pii_p2[PW-1], pii_p2});
      pi_p3    <= round_prod({pri_p2[PW-1], pri_p2} + {pir_p2[PW-1], pir_p2});
    end
  end

  // S4: sum/difference, optional halving, reduction to DATA_W
  always_comb begin
    sar = half_round(s4_sum(ar_p3, pr_p3, 1'b0), scale_p3);
    sai = half_round(s4_sum(ai_p3, pi_p3, 1'b0), scale_p3);
    sbr = half_round(s4_sum(ar_p3, pr_p3, 1'b1), scale_p3);
    sbi = half_round(s4_sum(ai_p3, pi_p3, 1'b1), scale_p3);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      out_a <= '0;
      out_b <= '0;
    end else if (advance) begin
      out_a <= {reduce(sai), reduce(sar)};
      out_b <= {reduce(sbi), reduce(sbr)};
    end
  end

`ifdef BFU_SAT_EN
  always_ff @(posedge clk) begin
    if (clear) ovf_flag <= 1'b0;
    else if (advance && vld_p3 && (oor(sar) || oor(sai) || oor(sbr) || oor(sbi)))
      ovf_flag <= 1'b1;
  end
`else
  assign ovf_flag = 1'b0;
`endif

endmodule
